// File: rtl/msx_bus_cycle.sv
// msx_bus_cycle
//   Recognises MSX memory and I/O read/write cycles on the filtered slot bus.
//   Each accepted cycle produces a one-clk request carrying the latched
//   address/data. WAIT is held low until the back-end acknowledges, the
//   timeout expires, or the CPU drops its strobe. Read data is then presented
//   to the bus tri-state logic.
//
//   State   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no cycle in progress
//   SETTLE  | cycle condition seen, counting stable ena samples
//   REQ     | request pulse out, WAIT asserted
//   WAIT_ACK| waiting for ack / timeout / strobe release
//   HOLD    | cycle completed, hold read data until strobes release
//   DRAIN   | CPU aborted, swallow the late ack (or timeout)
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   ena                                  sample enable shared with pin filters
//   sltsl_n, mreq_n, iorq_n, rd_n, wr_n, m1_n   filtered bus controls
//   addr[15:0], din[7:0]                 filtered address / data buses
//   req_valid, req_write, req_io,
//   req_addr[15:0], req_wdata[7:0]       request to back-end
//   ack, ack_rdata[7:0]                  back-end completion
//   rd_data[7:0], data_oe                read data toward bus drivers
//   wait_n                               MSX WAIT, active low
//   busy, timeout                        status
module msx_bus_cycle #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [7:0]  IO_BASE       = 8'h00,
    parameter logic [7:0]  IO_MASK       = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ena,
    input  logic        sltsl_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic        req_valid,
    output logic        req_write,
    output logic        req_io,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        ack,
    input  logic [7:0]  ack_rdata,
    output logic [7:0]  rd_data,
    output logic        data_oe,
    output logic        wait_n,
    output logic        busy,
    output logic        timeout
);

    localparam logic [3:0]  SETTLE_N  = 4'(SETTLE_CYCLES);
    localparam logic [16:0] TIMEOUT_N = 17'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_REQ, S_WAIT_ACK, S_HOLD, S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [16:0] tcnt_q, tcnt_d;
    logic        kind_io_q, kind_io_d;
    logic        kind_wr_q, kind_wr_d;
    logic        req_valid_q, req_valid_d;
    logic        req_write_q, req_write_d;
    logic        req_io_q, req_io_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        data_oe_q, data_oe_d;
    logic        wait_n_q, wait_n_d;
    logic        timeout_q, timeout_d;

    logic        one_strobe, port_match, mem_cyc, io_cyc, cyc_any, same_cyc;
    logic        strobe_gone, tc_hit, enter_req;
    logic [3:0]  settle_inc;
    logic [16:0] tcnt_inc;

    // Exactly one of rd_n/wr_n low; both low is never a cycle.
    assign one_strobe = rd_n ^ wr_n;
    assign port_match = (addr[7:0] & IO_MASK) == IO_BASE;
    assign mem_cyc    = ~sltsl_n & ~mreq_n & one_strobe;
    // m1_n low with iorq_n low is interrupt acknowledge, excluded here.
    assign io_cyc     = ~iorq_n & m1_n & port_match & one_strobe;
    assign cyc_any    = mem_cyc | io_cyc;
    // Memory wins when both match, so the kind is I/O only without mem_cyc.
    assign same_cyc   = cyc_any & (~mem_cyc == kind_io_q) & (~wr_n == kind_wr_q);
    assign strobe_gone = kind_wr_q ? wr_n : rd_n;
    assign settle_inc = settle_q + 4'd1;
    // Counter starts at zero when REQ is entered, so tcnt_inc is the number
    // of clks elapsed since req_valid at the upcoming edge.
    assign tcnt_inc   = tcnt_q + 17'd1;
    assign tc_hit     = tcnt_inc >= TIMEOUT_N;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            tcnt_q      <= '0;
            kind_io_q   <= 1'b0;
            kind_wr_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_io_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rd_data_q   <= 8'hFF;
            data_oe_q   <= 1'b0;
            wait_n_q    <= 1'b1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            tcnt_q      <= tcnt_d;
            kind_io_q   <= kind_io_d;
            kind_wr_q   <= kind_wr_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_io_q    <= req_io_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rd_data_q   <= rd_data_d;
            data_oe_q   <= data_oe_d;
            wait_n_q    <= wait_n_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        tcnt_d      = tcnt_q;
        kind_io_d   = kind_io_q;
        kind_wr_d   = kind_wr_q;
        req_valid_d = 1'b0;
        req_write_d = req_write_q;
        req_io_d    = req_io_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rd_data_d   = rd_data_q;
        data_oe_d   = data_oe_q;
        wait_n_d    = wait_n_q;
        timeout_d   = 1'b0;
        enter_req   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (ena && cyc_any) begin
                    kind_io_d = ~mem_cyc;
                    kind_wr_d = ~wr_n;
                    settle_d  = 4'd1;
                    if (SETTLE_N == 4'd1) enter_req = 1'b1;
                    else                  state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                tcnt_d = '0;
                if (ena) begin
                    if (same_cyc) begin
                        settle_d = settle_inc;
                        if (settle_inc == SETTLE_N) enter_req = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_REQ: begin
                tcnt_d  = tcnt_inc;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tcnt_d = tcnt_inc;
                if (ack) begin
                    wait_n_d = 1'b1;
                    if (!kind_wr_q) begin
                        rd_data_d = ack_rdata;
                        data_oe_d = 1'b1;
                    end
                    state_d = S_HOLD;
                end else if (tc_hit) begin
                    timeout_d = 1'b1;
                    wait_n_d  = 1'b1;
                    if (!kind_wr_q) begin
                        rd_data_d = 8'hFF;
                        data_oe_d = 1'b1;
                    end
                    state_d = S_HOLD;
                end else if (strobe_gone) begin
                    wait_n_d = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_HOLD: begin
                tcnt_d = '0;
                if (ena && rd_n && wr_n) begin
                    data_oe_d = 1'b0;
                    rd_data_d = 8'hFF;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                tcnt_d = tcnt_inc;
                if (ack) begin
                    state_d = S_IDLE;
                end else if (tc_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latch the request from the live bus on the accepting sample.
        if (enter_req) begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            wait_n_d    = 1'b0;
            tcnt_d      = '0;
            req_io_d    = ~mem_cyc;
            req_write_d = ~wr_n;
            req_addr_d  = addr;
            req_wdata_d = din;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        req_valid = req_valid_q;
        req_write = req_write_q;
        req_io    = req_io_q;
        req_addr  = req_addr_q;
        req_wdata = req_wdata_q;
        rd_data   = rd_data_q;
        data_oe   = data_oe_q;
        wait_n    = wait_n_q;
        timeout   = timeout_q;
    end

endmodule
